fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side drain engine for the dual-clock FIFO. It lives entirely in the read clock domain and pops words through the FIFO's registered read port (`rd_en` / `rd_data` / `rd_empty`). It re-times the 1-cycle pop latency through a 2-entry output buffer and presents the words as a valid/ready stream, framed into fixed-length bursts with a last flag. Full throughput is one word per cycle under no backpressure, and no word is lost or duplicated under arbitrary backpressure.

## Interface

**Parameters**

- `BITS`, 32: word width; must match the FIFO's `BITS`.
- `BURST`, 4: words per burst; `BURST` ≥ 1. The last word of each burst carries `out_last`.
- `CNT_BITS`, 16: width of the `bursts_sent` status counter.

**Ports**

- `rd_clk` in 1: read-domain clock, shared with the FIFO read side.
- `rd_rst_n` in 1: reset, synchronous, active-low; same net as the FIFO's `rd_rst_n`.
- `fifo_rd_en` out 1: pop request to the FIFO `rd_en`.
- `fifo_rd_data` in `BITS`: FIFO `rd_data`; updated one cycle after an accepted pop.
- `fifo_rd_empty` in 1: FIFO `rd_empty`.
- `out_valid` out 1: output word available.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out `BITS`: output word.
- `out_last` out 1: current word is the final word of a burst.
- `bursts_sent` out `CNT_BITS`: count of completed bursts; wraps modulo 2^`CNT_BITS`.

## Operation

**Terms**

- `accept` = `out_valid` && `out_ready`.
- `pop` = `fifo_rd_en` (asserted only when `fifo_rd_empty` = 0).

**Storage**

- 2-entry buffer: head and tail slots, plus occupancy `occ` ∈ {0, 1, 2}.
- 1-bit `inflight` flag, set the cycle after a `pop` (the word is on `fifo_rd_data` that cycle).

**Pop rule (combinational)**

- `fifo_rd_en` = !`fifo_rd_empty` && (`occ` + `inflight` − `accept`) < 2 && `rd_rst_n`.
- As a result, a word arriving on `fifo_rd_data` always has a free slot.

**Capture**

- When `inflight` = 1, `fifo_rd_data` is written into the first free slot at the end of that cycle, after accounting for a same-cycle `accept`.

**Output**

- `out_valid` = (`occ` > 0).
- `out_data` is the head slot.
- On `accept`, the tail moves to the head and `occ` decrements.
- Simultaneous `accept` and capture leaves `occ` unchanged.

**Burst framing**

- `beat` counter runs 0..`BURST`−1.
- `out_last` = `out_valid` && (`beat` == `BURST`−1).
- On `accept`: `beat` increments; at `BURST`−1 it wraps to 0 and `bursts_sent` increments.
- `beat` advances only on `accept`, never on pop.

**Stream rules**

- While `out_valid` && !`out_ready`, `out_data` and `out_last` hold stable and `out_valid` stays high.
- Words leave in FIFO order.

## Timing

**Reset (`rd_rst_n` = 0 sampled at a `rd_clk` edge)**

- All outputs are 0 after the edge: `out_valid`, `out_data`, `out_last`, `bursts_sent`.
- `occ`, `inflight`, and `beat` clear.
- `fifo_rd_en` is 0 combinationally throughout reset.

**Reset mid-operation**

- Buffered words and the in-flight word are discarded; the FIFO's read pointer resets on the same net.
- A partial burst is abandoned, and the next accepted word is beat 0.

**Latency**

- `fifo_rd_en` high in cycle N → word on `fifo_rd_data` in N+1 → `out_valid` with that word in N+2.
- Empty FIFO → first `out_valid` takes 2 cycles after `fifo_rd_empty` falls.

**Throughput and backpressure**

- Sustained 1 word/cycle with `out_ready` = 1 and the FIFO non-empty.
- With `out_ready` held low, at most 2 pops are issued, then `fifo_rd_en` stays 0.

**Boundary conditions**

- FIFO empties mid-burst: `out_valid` drops once the buffer drains; the burst resumes at the same `beat` when data returns.
- `bursts_sent` wraps from 2^`CNT_BITS`−1 to 0 without side effects.
- `BURST` = 1: `out_last` = `out_valid` on every word.

## Test plan

1. **Reset values.** Hold `rd_rst_n` = 0 for 3 cycles with the FIFO non-empty → `fifo_rd_en`, `out_valid`, `out_last`, `out_data`, and `bursts_sent` are all 0.
2. **Streaming and framing.** Preload the FIFO with 0x10..0x17, `out_ready` = 1 →
   - 8 consecutive beats 0x10..0x17, the first 2 cycles after the first pop;
   - `out_last` on 0x13 and 0x17;
   - `bursts_sent` = 2.
3. **Backpressure.** FIFO holds 5 words, `out_ready` = 0 for 10 cycles →
   - `fifo_rd_en` pulses exactly 2 times;
   - `out_data` = word 0, stable;
   - after `out_ready` = 1, all 5 words arrive in order, none duplicated.
4. **Random soak.** 1000 random words, random `out_ready` and random FIFO write gaps → scoreboard exact order, `out_last` on every 4th word, `fifo_rd_en` never high while `fifo_rd_empty` = 1.
5. **Reset mid-burst.** Reset after 2 accepted beats of a burst, then refill with 0xA0..0xA3 → no pre-reset word appears, `out_last` only on 0xA3, `bursts_sent` = 1.
6. **BURST = 1 wrap.** `BURST` = 1, `CNT_BITS` = 4, 17 words → `out_last` on every beat, `bursts_sent` ends at 1 after wrapping through 15 → 0.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: pops a registered-read FIFO, re-times the pop latency
// through a 2-entry buffer and emits a valid/ready stream framed into bursts.
module fifo_stream_reader #(
    parameter int BITS     = 32,
    parameter int BURST    = 4,
    parameter int CNT_BITS = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst_n,
    output logic                fifo_rd_en,
    input  logic [BITS-1:0]     fifo_rd_data,
    input  logic                fifo_rd_empty,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITS-1:0]     out_data,
    output logic                out_last,
    output logic [CNT_BITS-1:0] bursts_sent
);

    localparam int BEAT_W = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST - 1);

    logic [BITS-1:0]     head_q, head_d;
    logic [BITS-1:0]     tail_q, tail_d;
    logic [1:0]          occ_q, occ_d;
    logic                inflight_q, inflight_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [CNT_BITS-1:0] bursts_q, bursts_d;

    logic       accept;
    logic [1:0] occ_drained;
    logic [2:0] level;

    always_comb begin
        accept      = (occ_q != 2'd0) && out_ready;
        occ_drained = occ_q - {1'b0, accept};
        level       = {1'b0, occ_drained} + {2'b00, inflight_q};
        fifo_rd_en  = !fifo_rd_empty && (level < 3'd2) && rd_rst_n;
        inflight_d  = fifo_rd_en;

        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_drained;
        if (accept) begin
            head_d = tail_q;
        end
        // The returning word lands in the first slot still free after this
        // cycle's accept; the pop rule guarantees occ_drained < 2 here.
        if (inflight_q) begin
            if (occ_drained == 2'd0) begin
                head_d = fifo_rd_data;
            end else begin
                tail_d = fifo_rd_data;
            end
            occ_d = occ_drained + 2'd1;
        end

        beat_d   = beat_q;
        bursts_d = bursts_q;
        if (accept) begin
            if (beat_q == BEAT_LAST) begin
                beat_d   = '0;
                bursts_d = bursts_q + CNT_BITS'(1);
            end else begin
                beat_d = beat_q + BEAT_W'(1);
            end
        end
    end

    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            inflight_q <= 1'b0;
            beat_q     <= '0;
            bursts_q   <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            beat_q     <= beat_d;
            bursts_q   <= bursts_d;
        end
    end

    assign out_valid   = (occ_q != 2'd0);
    assign out_data    = head_q;
    assign out_last    = out_valid && (beat_q == BEAT_LAST);
    assign bursts_sent = bursts_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a queue-based FIFO model feeds the reader, written words are
// queued as expected stream beats, and a monitor compares every accepted word.
module tb_fifo_stream_reader;

    localparam int BITS = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, sel, rst_a, rst_b;
    logic [BITS-1:0] fifo_rd_data;
    logic            fifo_rd_empty, out_ready;

    logic            rd_en_a, valid_a, last_a;
    logic [BITS-1:0] data_a;
    logic [15:0]     bursts_a;
    logic            rd_en_b, valid_b, last_b;
    logic [BITS-1:0] data_b;
    logic [3:0]      bursts_b;

    // Instance A: BURST=4, 16-bit counter. Instance B: BURST=1, 4-bit counter.
    assign rst_a = sel ? 1'b0 : rst_n;
    assign rst_b = sel ? rst_n : 1'b0;

    fifo_stream_reader #(.BITS(BITS), .BURST(4), .CNT_BITS(16)) dut_a (
        .rd_clk(clk), .rd_rst_n(rst_a), .fifo_rd_en(rd_en_a),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .out_valid(valid_a), .out_ready(out_ready), .out_data(data_a),
        .out_last(last_a), .bursts_sent(bursts_a)
    );

    fifo_stream_reader #(.BITS(BITS), .BURST(1), .CNT_BITS(4)) dut_b (
        .rd_clk(clk), .rd_rst_n(rst_b), .fifo_rd_en(rd_en_b),
        .fifo_rd_data(fifo_rd_data), .fifo_rd_empty(fifo_rd_empty),
        .out_valid(valid_b), .out_ready(out_ready), .out_data(data_b),
        .out_last(last_b), .bursts_sent(bursts_b)
    );

    logic            cur_rd_en, cur_valid, cur_last;
    logic [BITS-1:0] cur_data;
    logic [15:0]     cur_bursts;
    assign cur_rd_en  = sel ? rd_en_b : rd_en_a;
    assign cur_valid  = sel ? valid_b : valid_a;
    assign cur_last   = sel ? last_b  : last_a;
    assign cur_data   = sel ? data_b  : data_a;
    assign cur_bursts = sel ? {12'd0, bursts_b} : bursts_a;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [BITS:0]   exp_q[$];
    logic [BITS-1:0] fifo_q[$];
    int          wr_idx, acc_total, cur_burst;
    logic [15:0] cnt_mask;
    bit          pop_pending;
    int          pop_cnt, first_pop, first_valid, last_acc_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stream position of each word is fixed at write time: nothing is lost or
    // duplicated between resets, so the n-th written word is the n-th beat.
    task automatic write_word(input logic [BITS-1:0] w);
        logic l;
        l = ((wr_idx % cur_burst) == (cur_burst - 1));
        fifo_q.push_back(w);
        exp_q.push_back({l, w});
        wr_idx++;
        fifo_rd_empty = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        fifo_q.delete();
        wr_idx        = 0;
        acc_total     = 0;
        pop_pending   = 1'b0;
        fifo_rd_empty = 1'b1;
    endtask

    // One clock: sample the pop request mid-cycle, then emulate the FIFO's
    // registered read port just after the edge.
    task automatic cycle();
        @(negedge clk);
        chk("pop_when_empty", {63'd0, cur_rd_en && fifo_rd_empty}, 64'd0);
        pop_pending = cur_rd_en;
        if (cur_rd_en) pop_cnt++;
        if (cur_rd_en && first_pop < 0) first_pop = cyc;
        if (cur_valid && first_valid < 0) first_valid = cyc;
        @(posedge clk);
        #1;
        if (pop_pending && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
        fifo_rd_empty = (fifo_q.size() == 0);
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (n) cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string name, input int maxc);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < maxc) begin
            cycle();
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_drain: %0d words left after %0d cycles, expected 0", name, exp_q.size(), maxc);
        end
    endtask

    task automatic check_bursts(input string name);
        chk(name, {48'd0, cur_bursts}, 64'((acc_total / cur_burst) & int'(cnt_mask)));
    endtask

    // Monitor: compares every accepted word and enforces hold-under-stall.
    bit              stall_prev = 1'b0;
    logic [BITS-1:0] stall_data;
    logic            stall_last;
    logic [BITS:0]   e;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", {63'd0, cur_valid}, 64'd1);
                chk("hold_data", {32'd0, cur_data}, {32'd0, stall_data});
                chk("hold_last", {63'd0, cur_last}, {63'd0, stall_last});
            end
            if (cur_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", cur_data);
                end else begin
                    e = exp_q.pop_front();
                    if (cur_data !== e[BITS-1:0] || cur_last !== e[BITS]) begin
                        failures++;
                        $display("FAIL stream_word: got data 0x%0h last %0b expected data 0x%0h last %0b",
                                 cur_data, cur_last, e[BITS-1:0], e[BITS]);
                    end
                end
                acc_total++;
                last_acc_cyc = cyc;
            end
            stall_prev = cur_valid && !out_ready;
            stall_data = cur_data;
            stall_last = cur_last;
        end
    end

    initial begin
        int written, k;
        sel          = 1'b0;
        rst_n        = 1'b0;
        out_ready    = 1'b0;
        fifo_rd_data = '0;
        cur_burst    = 4;
        cnt_mask     = 16'hFFFF;
        pop_cnt      = 0;
        first_pop    = -1;
        first_valid  = -1;
        last_acc_cyc = 0;
        model_reset();

        // Reset with a non-empty FIFO.
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hDEAD_0000 + BITS'(i));
        fifo_rd_empty = 1'b0;
        repeat (3) begin
            cycle();
            chk("rst_rd_en", {63'd0, cur_rd_en}, 64'd0);
            chk("rst_valid", {63'd0, cur_valid}, 64'd0);
            chk("rst_last", {63'd0, cur_last}, 64'd0);
            chk("rst_data", {32'd0, cur_data}, 64'd0);
            chk("rst_bursts", {48'd0, cur_bursts}, 64'd0);
        end
        model_reset();
        rst_n = 1'b1;

        // Streaming and framing.
        out_ready   = 1'b1;
        first_pop   = -1;
        first_valid = -1;
        for (int i = 0; i < 8; i++) write_word(32'h10 + BITS'(i));
        drain("t2", 40);
        chk("t2_latency", 64'(first_valid - first_pop), 64'd2);
        chk("t2_back_to_back", 64'(last_acc_cyc - first_valid), 64'd7);
        check_bursts("t2_bursts");

        // Backpressure.
        out_ready = 1'b0;
        pop_cnt   = 0;
        for (int i = 0; i < 5; i++) write_word(32'h30 + BITS'(i));
        repeat (10) cycle();
        chk("t3_pops", 64'(pop_cnt), 64'd2);
        chk("t3_head", {32'd0, cur_data}, 64'h30);
        out_ready = 1'b1;
        drain("t3", 40);
        check_bursts("t3_bursts");

        // Random soak.
        written = 0;
        k = 0;
        while ((written < 1000 || exp_q.size() != 0) && k < 20000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (written < 1000 && $urandom_range(0, 2) != 0) begin
                write_word($urandom);
                written++;
            end
            cycle();
            k++;
        end
        if (written < 1000 || exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL t4_soak_timeout: written %0d pending %0d, expected 1000 and 0", written, exp_q.size());
        end
        check_bursts("t4_bursts");

        // Reset mid-burst.
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) write_word(32'h50 + BITS'(i));
        k = 0;
        while (acc_total < 2 && k < 50) begin
            cycle();
            k++;
        end
        chk("t5_pre_accepts", 64'(acc_total), 64'd2);
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) write_word(32'hA0 + BITS'(i));
        drain("t5", 40);
        check_bursts("t5_bursts");

        // BURST=1, 4-bit counter wrap.
        rst_n     = 1'b0;
        sel       = 1'b1;
        cur_burst = 1;
        cnt_mask  = 16'h000F;
        do_reset(2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) write_word(32'hC0 + BITS'(i));
        drain("t6a", 60);
        check_bursts("t6_wrap_zero");
        write_word(32'hD0);
        drain("t6b", 20);
        check_bursts("t6_bursts");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
